// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if
// Groups the status inputs and datapath control outputs of the multicycle MIPS
// main controller.
//   master : controller side (drives control, samples Opcode/Zero)
//   slave  : datapath side (drives Opcode/Zero, consumes control)
// Signals:
//   Opcode[5:0] IR[31:26], Zero ALU zero flag,
//   PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], Done, IllegalOp,
//   State[3:0] (debug)
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       Done;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, Zero,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Done, IllegalOp, State
  );

  modport slave (
    output Opcode, Zero,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Done, IllegalOp, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Main control FSM for the multicycle MIPS datapath (Fetch/Decode/Execute/
// Memory/Writeback). Moore outputs decoded from the state; IllegalOp also
// looks at Opcode in DECODE, and PCEn looks at Zero for branches.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high, returns to FETCH
//   bus   : mips_multicycle_control_if.master (status in, control out)
module mips_multicycle_control (
  input  logic                            clk,
  input  logic                            reset,
  mips_multicycle_control_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  // lw/sw choice captured in DECODE so MEMADR never looks at Opcode again.
  logic   store_q;

  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        store_q <= (bus.Opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEXEC: begin
        state_d   = (state_q == S_ADDIEXEC) ? S_ADDIWB :
                    (store_q ? S_MEMWR : S_MEMRD);
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        state_d  = S_MEMWB;
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECUTE: begin
        state_d   = S_ALUWB;
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        branch    = 1'b1;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      // Encodings 12-15: all outputs stay 0 and we fall back to FETCH.
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked during reset so nothing is written in the reset cycle.
  assign bus.PCEn      = ~reset & (pc_write | (branch & bus.Zero));
  assign bus.MemRead   = ~reset & mem_read;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.Done      = ~reset & done;
  assign bus.IllegalOp = ~reset & illegal;
  assign bus.IorD      = iord;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.RegDst    = reg_dst;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.PCSource  = pc_source;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Directed bench for the multicycle MIPS main controller. Expected state
// sequences come from each opcode's instruction recipe; expected outputs come
// from a per-state control table plus reset masking and Zero for PCEn.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pcw;
    logic       br;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
    logic       done;
  } ctrl_t;

  typedef int iq_t[$];

  ctrl_t tab [16];
  ctrl_t e;
  int    exp_state = 0;
  bit    exp_rst = 1'b1;
  bit    chk_en = 1'b0;
  bit    legal;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s state=%0d: got %0d, expected %0d", name, exp_state, act, req);
    end
  endtask

  function automatic iq_t seq_for(input logic [5:0] opc);
    iq_t q;
    case (opc)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e = tab[exp_state];
      legal = (bus.Opcode inside {6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b001000, 6'b000010});
      chk("State",     int'(bus.State),    exp_state);
      chk("PCEn",      int'(bus.PCEn),     int'(!exp_rst && (e.pcw || (e.br && bus.Zero))));
      chk("IorD",      int'(bus.IorD),     int'(e.iord));
      chk("MemRead",   int'(bus.MemRead),  int'(!exp_rst && e.mrd));
      chk("MemWrite",  int'(bus.MemWrite), int'(!exp_rst && e.mwr));
      chk("IRWrite",   int'(bus.IRWrite),  int'(!exp_rst && e.irw));
      chk("MemtoReg",  int'(bus.MemtoReg), int'(e.m2r));
      chk("RegDst",    int'(bus.RegDst),   int'(e.rdst));
      chk("RegWrite",  int'(bus.RegWrite), int'(!exp_rst && e.rw));
      chk("ALUSrcA",   int'(bus.ALUSrcA),  int'(e.asa));
      chk("ALUSrcB",   int'(bus.ALUSrcB),  int'(e.asb));
      chk("ALUOp",     int'(bus.ALUOp),    int'(e.aop));
      chk("PCSource",  int'(bus.PCSource), int'(e.pcs));
      chk("Done",      int'(bus.Done),     int'(!exp_rst && e.done));
      chk("IllegalOp", int'(bus.IllegalOp), int'(!exp_rst && exp_state == 1 && !legal));
      // Hand-computed literals that pin the table itself.
      if (exp_state == 3 && !exp_rst)
        chk("lit_memrd", int'({bus.MemRead, bus.IorD}), 3);
      if (exp_state == 4)
        chk("lit_memwb", int'({bus.RegWrite, bus.MemtoReg, bus.Done}), 7);
      if (exp_state == 11)
        chk("lit_jump", int'({bus.PCEn, bus.PCSource}), 6);
      if (exp_state == 8 && bus.Zero)
        chk("lit_beq_taken", int'({bus.PCEn, bus.PCSource, bus.ALUOp}), 5'b1_01_01);
      if (exp_state == 8 && !bus.Zero)
        chk("lit_beq_not_taken", int'(bus.PCEn), 0);
      if (exp_state == 0 && exp_rst)
        chk("lit_reset_fetch", int'({bus.PCEn, bus.MemRead, bus.IRWrite}), 0);
    end
  end

  // Runs one instruction starting in FETCH. abort_idx >= 0 asserts reset in
  // that step of the sequence. tog randomises Opcode outside DECODE.
  task automatic run_instr(input logic [5:0] opc, input bit zb, input bit tog,
                           input int abort_idx);
    iq_t seq;
    seq = seq_for(opc);
    foreach (seq[i]) begin
      exp_state = seq[i];
      bus.Opcode = (seq[i] == 1 || !tog) ? opc : 6'($urandom);
      bus.Zero   = (seq[i] == 8) ? zb : 1'($urandom);
      if (i == abort_idx) begin
        reset   = 1'b1;
        exp_rst = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == abort_idx) begin
        reset   = 1'b0;
        exp_rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 16; s++) tab[s] = '0;
    // FETCH
    tab[0].mrd = 1; tab[0].irw = 1; tab[0].pcw = 1; tab[0].asb = 2'b01;
    // DECODE
    tab[1].asb = 2'b11;
    // MEMADR, ADDIEXEC
    tab[2].asa = 1; tab[2].asb = 2'b10;
    tab[9].asa = 1; tab[9].asb = 2'b10;
    // MEMRD
    tab[3].iord = 1; tab[3].mrd = 1;
    // MEMWB
    tab[4].m2r = 1; tab[4].rw = 1; tab[4].done = 1;
    // MEMWR
    tab[5].iord = 1; tab[5].mwr = 1; tab[5].done = 1;
    // EXECUTE
    tab[6].asa = 1; tab[6].aop = 2'b10;
    // ALUWB
    tab[7].rdst = 1; tab[7].rw = 1; tab[7].done = 1;
    // BRANCH
    tab[8].asa = 1; tab[8].aop = 2'b01; tab[8].pcs = 2'b01; tab[8].br = 1; tab[8].done = 1;
    // ADDIWB
    tab[10].rw = 1; tab[10].done = 1;
    // JUMP
    tab[11].pcs = 2'b10; tab[11].pcw = 1; tab[11].done = 1;

    bus.Opcode = 6'b0;
    bus.Zero   = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    // Second reset cycle: state is FETCH, strobes must be masked.
    exp_state = 0;
    exp_rst   = 1'b1;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_rst = 1'b0;

    run_instr(6'b100011, 1'b0, 1'b0, -1); // lw
    run_instr(6'b000000, 1'b0, 1'b0, -1); // R-type
    run_instr(6'b101011, 1'b0, 1'b0, -1); // sw
    run_instr(6'b000100, 1'b1, 1'b0, -1); // beq taken
    run_instr(6'b000100, 1'b0, 1'b0, -1); // beq not taken
    run_instr(6'b001000, 1'b0, 1'b0, -1); // addi
    run_instr(6'b000010, 1'b0, 1'b0, -1); // j
    run_instr(6'b111111, 1'b0, 1'b0, -1); // illegal
    run_instr(6'b100011, 1'b0, 1'b0, 3);  // lw aborted in MEMRD
    run_instr(6'b100011, 1'b0, 1'b1, -1); // lw, Opcode toggling
    run_instr(6'b000000, 1'b0, 1'b1, -1); // R-type, Opcode toggling
    run_instr(6'b101011, 1'b1, 1'b1, -1); // sw, Opcode toggling
    run_instr(6'b000100, 1'b1, 1'b1, -1); // beq, Opcode toggling
    run_instr(6'b000010, 1'b0, 1'b0, -1); // j after all of the above

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
